// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store requester and data_mem_responder.
// The requester drives the master side; the memory sits on the slave side.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering RV32I loads/stores after a fixed number
// of wait states, with size/alignment/range checking and a held response.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  // With zero wait states the access happens on the accepting edge, so it
  // must be computed from the live bus rather than the latched copy.
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [2:0]  acc_f3;
  logic [IdxW-1:0] acc_idx;
  logic [1:0]  lane;
  logic        in_range;
  logic        acc_err;
  logic [31:0] old_word;
  logic [31:0] shifted;
  logic [15:0] half;
  logic [3:0]  be;
  logic [31:0] wsh;
  logic [31:0] new_word;
  logic [31:0] load_val;
  logic        enter_resp;
  logic        mem_we;

  always_comb begin
    acc_write = (state_q == StIdle) ? bus.req_write  : write_q;
    acc_addr  = (state_q == StIdle) ? bus.req_addr   : addr_q;
    acc_wdata = (state_q == StIdle) ? bus.req_wdata  : wdata_q;
    acc_f3    = (state_q == StIdle) ? bus.req_funct3 : f3_q;
    acc_idx   = acc_addr[IdxW+1:2];
    lane      = acc_addr[1:0];
    in_range  = ({2'b00, acc_addr[31:2]} < 32'(DEPTH_WORDS));
  end

  always_comb begin
    acc_err = !in_range;
    if (acc_write) begin
      if (acc_f3 > 3'd2) acc_err = 1'b1;
    end else if (acc_f3 inside {3'd3, 3'd6, 3'd7}) begin
      acc_err = 1'b1;
    end
    if ((acc_f3 == 3'd1 || acc_f3 == 3'd5) && acc_addr[0]) acc_err = 1'b1;
    if (acc_f3 == 3'd2 && lane != 2'd0) acc_err = 1'b1;
  end

  always_comb begin
    old_word = mem_q[acc_idx];
    shifted  = old_word >> {lane, 3'b000};
    half     = acc_addr[1] ? old_word[31:16] : old_word[15:0];
    case (acc_f3[1:0])
      2'd0: begin
        be  = 4'b0001 << lane;
        wsh = {4{acc_wdata[7:0]}};
      end
      2'd1: begin
        be  = acc_addr[1] ? 4'b1100 : 4'b0011;
        wsh = {2{acc_wdata[15:0]}};
      end
      default: begin
        be  = 4'b1111;
        wsh = acc_wdata;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      new_word[8*b +: 8] = be[b] ? wsh[8*b +: 8] : old_word[8*b +: 8];
    end
    case (acc_f3)
      3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_val = {{16{half[15]}}, half};
      3'd2:    load_val = old_word;
      3'd4:    load_val = {24'd0, shifted[7:0]};
      3'd5:    load_val = {16'd0, half};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    enter_resp  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          f3_d    = bus.req_funct3;
          cnt_d   = CntInit;
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rdata_d     = 32'd0;
          err_d       = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      err_d       = acc_err;
      rdata_d     = (acc_write || acc_err) ? 32'd0 : load_val;
    end
    mem_we = enter_resp && acc_write && !acc_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      f3_q        <= 3'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      if (mem_we) mem_q[acc_idx] <= new_word;
    end
  end

  // Gated with reset so the requester never sees ready while held in reset.
  assign bus.req_ready = (state_q == StIdle) && reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = err_q;

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit storage words.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response (legal range 0-15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 req_valid  input  1  requester presents a memory access.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_funct3  input  3  RV32I size code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  requester accepts the response.
REQ-013 rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 rsp_error  output  1  access was rejected.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on the rising edge where req_valid=1 and req_ready=1.
REQ-018 On acceptance, all request fields SHALL be latched; later input changes have no effect on the access.
REQ-019 On acceptance, the FSM SHALL go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
REQ-020 In WAIT, the counter SHALL decrement each cycle; when the counter is 0, the next edge moves the FSM to RESP.
REQ-021 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-022 The access (store commit or load capture) SHALL occur on the edge entering RESP.
REQ-023 In RESP, rsp_valid=1 and rsp_rdata/rsp_error SHALL hold stable until the edge with rsp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-024 rsp_ready SHALL be ignored outside RESP.
REQ-025 No request SHALL be accepted in the RESP-exit cycle; the earliest next acceptance is the following cycle.
REQ-026 Word index SHALL be req_addr[31:2] and byte lane SHALL be req_addr[1:0].
REQ-027 Error conditions SHALL be: H/HU with addr[0]=1; W with addr[1:0]!=0; word index >= DEPTH_WORDS; load funct3 in {3,6,7}; store funct3 > 2.
REQ-028 On error, there SHALL be no storage write, rsp_error=1 and rsp_rdata=0.
REQ-029 SB SHALL write wdata[7:0] to the addressed byte lane; SH SHALL write wdata[15:0] to lanes {addr[1],0}+1:0; SW SHALL write all lanes; unaddressed lanes SHALL be unchanged.
REQ-030 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected lane(s); LW SHALL return the full word.
REQ-031 Successful stores SHALL respond with rsp_error=0 and rsp_rdata=0.

Reset
REQ-032 While reset=0 (asynchronously), the block SHALL force FSM=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_error=0 and clear all storage words to 0.
REQ-033 req_ready SHALL be 0 while reset=0 and 1 on the first cycle after release.
REQ-034 Reset during WAIT SHALL discard the pending access; a pending store SHALL not be committed.
REQ-035 Reset during RESP SHALL drop the response without a handshake.

Verification
REQ-036 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_error=0, rsp_valid exactly 3 cycles after each accept (default WAIT_CYCLES).
REQ-037 After REQ-036, SB 0x11 data 0x80 then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LHU 0x12 -> 0x0000DEAD.
REQ-038 LW 0x02, SH 0x03, LW 0x100 (DEPTH 64) -> each returns rsp_error=1, rsp_rdata=0; a following LW 0x00 returns 0 (storage untouched).
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_error stable and req_ready=0 throughout; the request is accepted only after the handshake.
REQ-040 SW 0x20 data 0x12345678, assert reset during WAIT -> after release, LW 0x20 returns 0.
REQ-041 With WAIT_CYCLES=0, back-to-back loads with rsp_ready tied high -> rsp_valid one cycle after each accept; accepts occur every 2 cycles.
